// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - tag FIFO between index extractor and tag compare
// First-word-fall-through register FIFO with almost-full back-pressure and sticky error flags.
module tag_fifo #(
   parameter int ADDR_WIDTH   = 64,
   parameter int TID_WIDTH    = 10,
   parameter int DATA_WIDTH   = ADDR_WIDTH + TID_WIDTH + 1,
   parameter int DEPTH_LG2    = 4,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wren_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  afull_o,
   output logic                  full_o,
   input  logic                  rden_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  empty_o,
   output logic [DEPTH_LG2:0]    count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int DEPTH = 1 << DEPTH_LG2;
   localparam logic [DEPTH_LG2:0] FULL_CNT  = (DEPTH_LG2+1)'(DEPTH);
   localparam logic [DEPTH_LG2:0] AFULL_CNT = (DEPTH_LG2+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [DEPTH_LG2-1:0] PTR_ONE = (DEPTH_LG2)'(1);
   localparam logic [DEPTH_LG2:0]   CNT_ONE = (DEPTH_LG2+1)'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH_LG2-1:0]  wptr_q, wptr_d;
   logic [DEPTH_LG2-1:0]  rptr_q, rptr_d;
   logic [DEPTH_LG2:0]    count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  full, empty, wr_ok, rd_ok;

   // Status decodes come only from the count register, never from the strobes.
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign wr_ok = wren_i && !full;
   assign rd_ok = rden_i && !empty;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (wr_ok) begin
         wptr_d = wptr_q + PTR_ONE;
      end else if (wren_i) begin
         overflow_d = 1'b1;
      end
      if (rd_ok) begin
         rptr_d = rptr_q + PTR_ONE;
      end else if (rden_i) begin
         underflow_d = 1'b1;
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Array is not cleared on reset; a write coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o     = mem_q[rptr_q];
   assign empty_o     = empty;
   assign full_o      = full;
   assign afull_o     = (count_q >= AFULL_CNT);
   assign count_o     = count_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule

// File: tb/tb_tag_fifo.sv
// tb/tb_tag_fifo.sv - self-checking bench for tag_fifo
// Queue-based reference model; directed scenarios followed by randomized traffic.
module tb_tag_fifo;

   localparam int DW = 75;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wren_i = 1'b0;
   logic [DW-1:0] wdata_i = '0;
   logic          rden_i = 1'b0;
   logic          afull_o, full_o, empty_o, overflow_o, underflow_o;
   logic [DW-1:0] rdata_o;
   logic [4:0]    count_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] q[$];
   logic          m_ov = 1'b0;
   logic          m_un = 1'b0;

   tag_fifo dut (
      .clk(clk), .rst(rst), .wren_i(wren_i), .wdata_i(wdata_i),
      .afull_o(afull_o), .full_o(full_o), .rden_i(rden_i), .rdata_o(rdata_o),
      .empty_o(empty_o), .count_o(count_o), .overflow_o(overflow_o),
      .underflow_o(underflow_o)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] entry(input logic rw, input logic [9:0] tid,
                                           input logic [63:0] addr);
      return {rw, tid, addr};
   endfunction

   function automatic logic [DW-1:0] rnd_entry(input logic [9:0] tid);
      logic [63:0] a;
      a = {$urandom, $urandom};
      return entry(1'($urandom_range(0, 1)), tid, a);
   endfunction

   // Drive one cycle; model updates from the pre-edge occupancy.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
      bit was_full, was_empty;
      wren_i = w; wdata_i = d; rden_i = r; rst = rs;
      @(posedge clk);
      if (rs) begin
         q.delete(); m_ov = 1'b0; m_un = 1'b0;
      end else begin
         was_full  = (q.size() == 16);
         was_empty = (q.size() == 0);
         if (r && !was_empty) void'(q.pop_front());
         else if (r) m_un = 1'b1;
         if (w && !was_full) q.push_back(d);
         else if (w) m_ov = 1'b1;
      end
      #1;
      wren_i = 1'b0; rden_i = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      step(0, '0, 0, 1);
      step(0, '0, 0, 1);
      n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
      n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full_o); end
      n_checks++; if (afull_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b exp=0", afull_o); end
      n_checks++; if (count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
      n_checks++; if ({overflow_o, underflow_o} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", overflow_o, underflow_o); end
   endtask

   task automatic test_single();
      logic [DW-1:0] e;
      e = entry(1'b0, 10'd1, 64'h1040);
      step(1, e, 0, 0);
      n_checks++; if (empty_o !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", empty_o); end
      n_checks++; if (count_o !== 5'd1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", count_o); end
      n_checks++; if (rdata_o !== e) begin n_fail++; $display("FAIL single_rdata got=%h exp=%h", rdata_o, e); end
      step(0, '0, 1, 0);
      n_checks++; if (empty_o !== 1'b1 || count_o !== 5'd0) begin n_fail++; $display("FAIL single_pop got=%b/%0d exp=1/0", empty_o, count_o); end
   endtask

   task automatic test_fill();
      logic [DW-1:0] head;
      for (int i = 0; i < 14; i++) begin
         step(1, rnd_entry(10'(i + 1)), 0, 0);
         if (i == 12) begin
            n_checks++; if (afull_o !== 1'b0) begin n_fail++; $display("FAIL fill_afull13 got=%b exp=0", afull_o); end
         end
      end
      n_checks++; if (count_o !== 5'd14 || afull_o !== 1'b1 || full_o !== 1'b0)
         begin n_fail++; $display("FAIL fill_14 got=cnt%0d af%b f%b exp=cnt14 af1 f0", count_o, afull_o, full_o); end
      step(1, rnd_entry(10'd15), 0, 0);
      step(1, rnd_entry(10'd16), 0, 0);
      n_checks++; if (count_o !== 5'd16 || full_o !== 1'b1)
         begin n_fail++; $display("FAIL fill_16 got=cnt%0d f%b exp=cnt16 f1", count_o, full_o); end
      head = q[0];
      step(1, rnd_entry(10'd17), 0, 0);
      n_checks++; if (overflow_o !== 1'b1 || count_o !== 5'd16 || rdata_o !== head)
         begin n_fail++; $display("FAIL fill_overflow got=ov%b cnt%0d head%h exp=ov1 cnt16 head%h", overflow_o, count_o, rdata_o, head); end
      step(0, '0, 0, 1);
   endtask

   task automatic test_wrap();
      for (int i = 1; i <= 16; i++) step(1, rnd_entry(10'(i)), 0, 0);
      for (int i = 0; i < 10; i++) step(0, '0, 1, 0);
      for (int i = 17; i <= 26; i++) step(1, rnd_entry(10'(i)), 0, 0);
      for (int i = 11; i <= 26; i++) begin
         n_checks++; if (rdata_o[73:64] !== 10'(i) || rdata_o !== q[0])
            begin n_fail++; $display("FAIL wrap_order got=tid%0d exp=tid%0d", rdata_o[73:64], i); end
         step(0, '0, 1, 0);
      end
      n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got=%b exp=1", empty_o); end
   endtask

   task automatic test_simultaneous();
      logic [DW-1:0] e;
      step(0, '0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, rnd_entry(10'(100 + i)), 0, 0);
      step(1, rnd_entry(10'd105), 1, 0);
      n_checks++; if (count_o !== 5'd5) begin n_fail++; $display("FAIL simul_count5 got=%0d exp=5", count_o); end
      for (int i = 1; i <= 5; i++) begin
         n_checks++; if (rdata_o[73:64] !== 10'(100 + i) || rdata_o !== q[0])
            begin n_fail++; $display("FAIL simul_order got=tid%0d exp=tid%0d", rdata_o[73:64], 100 + i); end
         step(0, '0, 1, 0);
      end
      e = rnd_entry(10'd200);
      step(1, e, 1, 0);
      n_checks++; if (count_o !== 5'd1 || underflow_o !== 1'b1 || rdata_o !== e)
         begin n_fail++; $display("FAIL simul_empty got=cnt%0d un%b exp=cnt1 un1", count_o, underflow_o); end
      step(0, '0, 0, 1);
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] e;
      for (int i = 0; i < 7; i++) step(1, rnd_entry(10'(300 + i)), 0, 0);
      step(0, '0, 1, 0);
      step(1, rnd_entry(10'd307), 0, 0);
      step(1, rnd_entry(10'd308), 1, 1);
      n_checks++; if (count_o !== 5'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || underflow_o !== 1'b0)
         begin n_fail++; $display("FAIL rstmid got=cnt%0d e%b ov%b un%b exp=cnt0 e1 ov0 un0", count_o, empty_o, overflow_o, underflow_o); end
      e = rnd_entry(10'd400);
      step(1, e, 0, 0);
      n_checks++; if (rdata_o !== e || count_o !== 5'd1)
         begin n_fail++; $display("FAIL rstmid_after got=%h cnt%0d exp=%h cnt1", rdata_o, count_o, e); end
   endtask

   task automatic test_random();
      bit w, r, rs;
      for (int i = 0; i < 600; i++) begin
         w  = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 45);
         rs = ($urandom_range(0, 199) == 0);
         step(w, rnd_entry(10'($urandom)), r, rs);
         n_checks++;
         if (count_o !== 5'(q.size()) || empty_o !== (q.size() == 0) || full_o !== (q.size() == 16)
             || afull_o !== (q.size() >= 14) || overflow_o !== m_ov || underflow_o !== m_un
             || (q.size() != 0 && rdata_o !== q[0])) begin
            n_fail++;
            $display("FAIL random cyc%0d got=cnt%0d e%b f%b af%b ov%b un%b exp=cnt%0d ov%b un%b",
                     i, count_o, empty_o, full_o, afull_o, overflow_o, underflow_o, q.size(), m_ov, m_un);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
